// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and pointer helpers for the single-clock FIFO
package fifo_pkg;

    localparam int DSIZE_DEF = 8;
    localparam int ASIZE_DEF = 4;

    // Full when the pointers differ only in the wrap bit.
    function automatic logic ptr_full(input logic [31:0] wp, input logic [31:0] rp, input int asize);
        logic [31:0] mask;
        mask = (32'd1 << (asize + 1)) - 32'd1;
        return ((wp ^ rp) & mask) == (32'd1 << asize);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: register-array storage with sync write/clear and async read
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    logic [DSIZE-1:0] mem [2**ASIZE];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**ASIZE; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/async_fifo_1.sv
// async_fifo_1: single-clock first-word-fall-through FIFO with registered flags
module async_fifo_1
    import fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty
);

    logic [ASIZE:0] wptr, rptr, wptr_next, rptr_next;
    logic           wen, ren;

    assign wen       = winc && !wfull;
    assign ren       = rinc && !rempty;
    assign wptr_next = wptr + {{ASIZE{1'b0}}, wen};
    assign rptr_next = rptr + {{ASIZE{1'b0}}, ren};

    // Flags are registered from next-state pointers so they never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr   <= '0;
            rptr   <= '0;
            rempty <= 1'b1;
            wfull  <= 1'b0;
        end else begin
            wptr   <= wptr_next;
            rptr   <= rptr_next;
            rempty <= rptr_next == wptr_next;
            wfull  <= ptr_full(32'(wptr_next), 32'(rptr_next), ASIZE);
        end
    end

    fifo_mem #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wen),
        .waddr (wptr[ASIZE-1:0]),
        .wdata (wdata),
        .raddr (rptr[ASIZE-1:0]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_async_fifo_1.sv
// tb_async_fifo_1: scoreboard bench for the single-clock FWFT FIFO
module tb_async_fifo_1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       winc = 1'b1, rinc = 1'b1;
    logic [7:0] wdata = 8'h77;
    logic       wfull, rempty;
    logic [7:0] rdata;
    logic [7:0] q[$];
    int         errors = 0, checks = 0;

    async_fifo_1 dut (
        .clk    (clk),
        .rst    (rst),
        .winc   (winc),
        .wdata  (wdata),
        .wfull  (wfull),
        .rinc   (rinc),
        .rdata  (rdata),
        .rempty (rempty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge: compare outputs with the model, drive inputs, advance the model.
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        logic can_w, can_r;
        check("rempty", rempty, q.size() == 0);
        check("wfull", wfull, q.size() == 16);
        if (q.size() > 0) check("rdata", rdata, q[0]);
        can_w = w && q.size() < 16;
        can_r = r && q.size() > 0;
        winc = w; rinc = r; wdata = d;
        if (can_r) void'(q.pop_front());
        if (can_w) q.push_back(d);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; winc = 1'b1; rinc = 1'b1; wdata = 8'h77;
        repeat (n) begin
            @(negedge clk);
            check("rst_empty", rempty, 1'b1);
            check("rst_full", wfull, 1'b0);
            check("rst_rdata", rdata, 8'h00);
        end
        rst = 1'b0; winc = 1'b0; rinc = 1'b0;
        q.delete();
    endtask

    initial begin
        int nw;
        do_reset(5);
        step(0, 0, 0);
        // single word
        step(1, 0, 8'hA5);
        check("single", rdata, 8'hA5);
        step(0, 1, 0);
        step(0, 0, 0);
        // fill, overflow, drain
        for (int i = 0; i < 16; i++) step(1, 0, 8'(i));
        check("full16", wfull, 1'b1);
        step(1, 0, 8'hFF);
        for (int i = 0; i < 16; i++) step(0, 1, 0);
        step(0, 0, 0);
        // wrap-around: two rounds with reads at 2 per 7 cycles
        nw = 0;
        for (int c = 0; c < 400 && (nw < 32 || q.size() > 0); c++) begin
            logic w, r, acc;
            w = nw < 32;
            r = (c % 7 == 0) || (c % 7 == 3) || nw >= 32;
            acc = w && q.size() < 16;
            step(w, r, 8'($urandom));
            if (acc) nw++;
        end
        check("wrap_done", q.size(), 0);
        step(0, 0, 0);
        // simultaneous access at occupancy 8
        for (int i = 0; i < 8; i++) step(1, 0, 8'($urandom));
        for (int i = 0; i < 10; i++) step(1, 1, 8'($urandom));
        check("occ8", q.size(), 8);
        for (int i = 0; i < 8; i++) step(1, 0, 8'($urandom));
        check("full_sim", wfull, 1'b1);
        step(1, 1, 8'hEE);
        check("full_rw", wfull, 1'b0);
        for (int i = 0; i < 15; i++) step(0, 1, 0);
        step(0, 0, 0);
        // underflow
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        step(1, 0, 8'h11);
        check("after_underflow", rdata, 8'h11);
        step(0, 1, 0);
        step(0, 0, 0);
        // mid-run reset
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h50 + i));
        do_reset(1);
        step(1, 0, 8'h3C);
        check("post_rst", rdata, 8'h3C);
        step(0, 1, 0);
        step(0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/async_fifo_1.md
# async_fifo_1

Single-clock, first-word-fall-through FIFO buffering DSIZE-bit words, 2^ASIZE deep, between a producer and a consumer in the same clock domain. It replaces the dual-clock FIFO slot in the datapath; producer and consumer each see their own increment and status signals. The block keeps the original port names, except that one clock and one reset replace the per-side clocks and resets.

## Interface
- DSIZE, 8, data word width in bits
- ASIZE, 4, address width; depth = 2^ASIZE (16 by default)

Ports:
- clk  in  1  the single clock for both sides; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset; sampled on the rising edge of clk
- winc  in  1  write request; wdata is stored on the edge when winc=1 and wfull=0
- wdata  in  DSIZE  write data
- wfull  out  1  FIFO holds 2^ASIZE words
- rinc  in  1  read request; the head word is popped on the edge when rinc=1 and rempty=0
- rdata  out  DSIZE  head-of-FIFO word, valid whenever rempty=0
- rempty  out  1  FIFO holds 0 words

## Operation
- Storage: 2^ASIZE x DSIZE register array.
- Pointers:
  - Binary write pointer wptr and read pointer rptr, each ASIZE+1 bits.
  - The low ASIZE bits address the memory; the MSB is a wrap bit.
  - Pointers wrap modulo 2^(ASIZE+1).
- Write: if winc && !wfull, mem[wptr[ASIZE-1:0]] <= wdata and wptr <= wptr+1.
- Read: if rinc && !rempty, rptr <= rptr+1.
- rdata is combinational: mem[rptr[ASIZE-1:0]], so the head word is presented before it is popped (first-word fall-through).
- Flags are registered and computed from the next-state pointers:
  - rempty_next = (rptr_next == wptr_next)
  - wfull_next = (wptr_next[ASIZE] != rptr_next[ASIZE]) && (wptr_next[ASIZE-1:0] == rptr_next[ASIZE-1:0])
- Rejected operations:
  - A write while full is dropped silently; wptr and memory are unchanged.
  - A read while empty is ignored; rptr is unchanged.
- Simultaneous winc and rinc:
  - Not full and not empty: both occur and occupancy is unchanged.
  - When full: only the read occurs. The write is dropped because wfull is evaluated on the current registered flag.
  - When empty: only the write occurs. The same word is not readable until the next cycle.
- Reset (rst=1 on an edge):
  - wptr=0, rptr=0, all memory words cleared to 0.
  - rempty=1, wfull=0, so rdata=0.
  - Reset overrides any concurrent winc or rinc.
  - A reset in mid-operation discards all contents.

## Timing
- Write-to-visibility latency is 1 cycle. After the edge that writes into an empty FIFO, rempty=0 and rdata shows that word in the following cycle.
- A read pops on the edge. The next word, or rempty=1, is visible after that edge.
- After the 2^ASIZE-th net write, wfull=1 from that edge onward. After one read, wfull=0 on the next edge.
- Flags never glitch; they change only on clk edges.
- No synchronizer stages exist, since there is one clock.

## Structure
- Shared package fifo_pkg holds:
  - Default constants DSIZE_DEF=8 and ASIZE_DEF=4.
  - A helper function for the full comparison.
- One sub-module, fifo_mem:
  - Parameterized storage array.
  - Synchronous write port with synchronous clear.
  - Asynchronous read port.
- The top level holds pointers and flag logic.

## Test plan
- Reset: assert rst for 5 cycles with winc=rinc=1 -> rempty=1, wfull=0, rdata=0 throughout and after release.
- Single word: write 0xA5 once -> next cycle rempty=0, rdata=0xA5. Pulse rinc -> rempty=1 after the edge.
- Fill and overflow:
  - Write 0x00..0x0F over 16 cycles -> wfull=1 after the 16th edge.
  - A 17th write of 0xFF is dropped.
  - Draining returns 0x00..0x0F in order, then rempty=1.
- Wrap-around: two rounds of 16 random writes and 16 reads, interleaved at a consumer duty of 1 read per 3.5 write cycles -> every read matches a scoreboard queue and wptr/rptr wrap without data loss.
- Simultaneous access:
  - Hold 8 words and assert winc+rinc for 10 cycles -> occupancy stays 8 and data stays in order.
  - At full, winc+rinc -> read succeeds, write dropped, wfull=0 next cycle.
- Underflow and mid-run reset:
  - rinc on empty -> no pointer change, rempty stays 1.
  - Reset with 5 words held -> rempty=1, and the next written word 0x3C appears as rdata.
